// File: rtl/adder8_pkg.sv
// Shared constants for the pipelined 8-bit adder.
// The fabric pin map is built around the default width.
package adder8_pkg;

  localparam int   ADDER_WIDTH  = 8;
  localparam logic RESET_ACTIVE = 1'b0;

endpackage : adder8_pkg

// File: rtl/adder8_full_adder_cell.sv
// One bit of the ripple-carry chain.
// Generate and propagate are kept as named nets so the mapper can see them.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic gen_bit;
  logic prop_bit;

  assign gen_bit  = a & b;
  assign prop_bit = a ^ b;
  assign s        = prop_bit ^ ci;
  assign co       = gen_bit | (ci & prop_bit);

endmodule : full_adder_cell

// File: rtl/adder8_top.sv
// Two-stage pipelined unsigned adder: operand register, ripple-carry chain, sum register.
// Outputs come straight from flops and serve as the golden reference for fabric data-out.
module adder8_top
  import adder8_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ACTIVE) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
    end else begin
      a_reg   <= a;
      b_reg   <= b;
      cin_reg <= cin;
    end
  end

  assign carry[0] = cin_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      full_adder_cell u_fa (
        .a  (a_reg[gi]),
        .b  (b_reg[gi]),
        .ci (carry[gi]),
        .s  (sum_next[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Stage 2: the chain's final carry becomes cout.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ACTIVE) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum_next;
      cout <= carry[WIDTH];
    end
  end

endmodule : adder8_top

// File: tb/tb_adder8_top.sv
// Directed self-checking bench for adder8_top: reset, carry corners, sweep, async reset, pipelining.
`timescale 1ns/1ps
module tb_adder8_top;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s;
  logic       cout;

  int vectors;
  int miscompares;

  adder8_top #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is well under 1 ms.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a   = av;
    b   = bv;
    cin = cv;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(8'h5A, 8'h33, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({cout, s} !== 9'h000) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got cout=%b s=%h, required cout=0 s=00", i, cout, s);
      end else
        $display("reset_hold[%0d] cout=%b s=%h", i, cout, s);
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({cout, s} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_release_e1: got cout=%b s=%h, required cout=0 s=00", cout, s);
    end else
      $display("reset_release_e1 cout=%b s=%h", cout, s);
    step();
    vectors++;
    if ({cout, s} !== 9'h08E) begin
      miscompares++;
      $display("FAIL reset_release_e2: got cout=%b s=%h, required cout=0 s=8e", cout, s);
    end else
      $display("reset_release_e2 cout=%b s=%h", cout, s);
  endtask

  task automatic test_corners();
    logic [7:0] av [4]  = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
    logic [7:0] bv [4]  = '{8'hFF, 8'hFF, 8'h01, 8'h01};
    logic       cv [4]  = '{1'b1,  1'b0,  1'b0,  1'b0};
    logic [8:0] exp [4] = '{9'h1FF, 9'h1FE, 9'h100, 9'h080};
    for (int i = 0; i < 4; i++) begin
      drive(av[i], bv[i], cv[i]);
      step();
      step();
      vectors++;
      if ({cout, s} !== exp[i]) begin
        miscompares++;
        $display("FAIL corner[%0d] %h+%h+%b: got cout=%b s=%h, required cout=%b s=%h",
                 i, av[i], bv[i], cv[i], cout, s, exp[i][8], exp[i][7:0]);
      end else
        $display("corner[%0d] %h+%h+%b -> cout=%b s=%h", i, av[i], bv[i], cv[i], cout, s);
    end
  endtask

  task automatic test_sweep();
    logic [8:0] prev_exp;
    logic       c;
    int         bad;
    bad = 0;
    prev_exp = '0;
    for (int k = 0; k <= 65536; k++) begin
      if (k < 65536) begin
        c = 1'($urandom_range(0, 1));
        drive(8'(k >> 8), 8'(k), c);
      end
      step();
      // After edge k, the output holds the vector applied before edge k-1.
      if (k >= 1) begin
        vectors++;
        if ({cout, s} !== prev_exp) begin
          miscompares++;
          bad++;
          if (bad <= 10)
            $display("FAIL sweep[%0d]: got cout=%b s=%h, required cout=%b s=%h",
                     k - 1, cout, s, prev_exp[8], prev_exp[7:0]);
        end
      end
      if (k < 65536)
        prev_exp = 9'(k >> 8) + 9'(k & 8'hFF) + 9'(c);
    end
    $display("sweep: 65536 operand pairs checked, %0d bad", bad);
  endtask

  task automatic test_async_reset();
    drive(8'h12, 8'h34, 1'b1);
    step();
    step();
    vectors++;
    if ({cout, s} !== 9'h047) begin
      miscompares++;
      $display("FAIL async_pre: got cout=%b s=%h, required cout=0 s=47", cout, s);
    end else
      $display("async_pre cout=%b s=%h", cout, s);
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({cout, s} !== 9'h000) begin
      miscompares++;
      $display("FAIL async_during: got cout=%b s=%h, required cout=0 s=00", cout, s);
    end else
      $display("async_during cout=%b s=%h", cout, s);
    #2;
    reset = 1'b1;
    drive(8'hA0, 8'h0B, 1'b0);
    step();
    vectors++;
    if ({cout, s} !== 9'h000) begin
      miscompares++;
      $display("FAIL async_release_e1: got cout=%b s=%h, required cout=0 s=00", cout, s);
    end else
      $display("async_release_e1 cout=%b s=%h", cout, s);
    step();
    vectors++;
    if ({cout, s} !== 9'h0AB) begin
      miscompares++;
      $display("FAIL async_release_e2: got cout=%b s=%h, required cout=0 s=ab", cout, s);
    end else
      $display("async_release_e2 cout=%b s=%h", cout, s);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_s [3] = '{8'h11, 8'h12, 8'h13};
    drive(8'h01, 8'h10, 1'b0);
    step();
    drive(8'h02, 8'h10, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({cout, s} !== {1'b0, exp_s[i]}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got cout=%b s=%h, required cout=0 s=%h", i, cout, s, exp_s[i]);
      end else
        $display("b2b[%0d] cout=%b s=%h", i, cout, s);
      if (i == 0)
        drive(8'h03, 8'h10, 1'b0);
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    test_reset();
    test_corners();
    test_sweep();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_adder8_top
